cache_tag_lookup_assoc: RTL and testbench

Parametrised N-way set-associative tag store and lookup engine for the core's data/instruction cache. It holds the tag and valid arrays internally and accepts CPU lookups through a valid/ready handshake. Each accepted lookup produces a registered hit/miss response one cycle later, together with the hit way and the replacement victim way. It also services line fills from the cache controller and performs a full sequential invalidate (flush).

---
 rtl/cache_tag_lookup_assoc.sv | 183 ++++++++++++++++++
 tb/tb_cache_tag_lookup_assoc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_lookup_assoc.sv
// N-way set-associative tag store with one-cycle registered lookup, victim
// selection (first invalid way, else per-set round robin), fills and a sequential flush.

module cache_tag_way_cmp #(
  parameter int TAG_W = 28
) (
  input  logic [TAG_W-1:0] way_tag,
  input  logic             way_vld,
  input  logic [TAG_W-1:0] req_tag,
  output logic             hit
);
  assign hit = way_vld && (way_tag == req_tag);
endmodule

module cache_tag_lookup_assoc #(
  parameter  int ADDR_W = 32,
  parameter  int SET_W  = 2,
  parameter  int WORD_W = 2,
  parameter  int OFF_W  = 0,
  parameter  int WAYS   = 2,
  localparam int TAG_W  = ADDR_W - SET_W - WORD_W - OFF_W,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [SET_W-1:0]  req_set,
  input  logic [WORD_W-1:0] req_word,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_miss,
  output logic [WAY_W-1:0]  rsp_way,
  output logic [WAY_W-1:0]  rsp_victim,
  output logic              rsp_multi,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [SET_W-1:0]  rsp_set,
  output logic [WORD_W-1:0] rsp_word,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [SET_W-1:0]  fill_set,
  output logic [WAY_W-1:0]  fill_way,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done
);
  localparam int SETS = 1 << SET_W;

  typedef enum logic {IDLE, FLUSH} state_e;

  typedef struct packed {
    logic              hit;
    logic              miss;
    logic              multi;
    logic [WAY_W-1:0]  way;
    logic [WAY_W-1:0]  victim;
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [WORD_W-1:0] word;
  } rsp_t;

  state_e                       state_q, state_d;
  logic [SET_W-1:0]             cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;
  logic [TAG_W-1:0]             tag_q [SETS][WAYS];
  logic [TAG_W-1:0]             tag_d [SETS][WAYS];
  rsp_t                         rsp_q, rsp_d;
  logic                         rsp_valid_q, rsp_valid_d;

  logic [WAYS-1:0][TAG_W-1:0]   set_tags;
  logic [WAYS-1:0]              hit_vec;
  logic [WAY_W-1:0]             hit_way;

  // Lowest invalid way wins; a full set falls back to its round-robin pointer.
  function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS-1:0] v,
                                                   input logic [WAY_W-1:0] rr);
    logic [WAY_W-1:0] r;
    r = rr;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!v[w]) r = WAY_W'(w);
    if (WAYS == 1) r = '0;
    return r;
  endfunction

  always_comb begin
    for (int w = 0; w < WAYS; w++) set_tags[w] = tag_q[req_set][w];
  end

  cache_tag_way_cmp #(.TAG_W(TAG_W)) u_cmp [WAYS-1:0] (
    .way_tag (set_tags),
    .way_vld (valid_q[req_set]),
    .req_tag ({WAYS{req_tag}}),
    .hit     (hit_vec)
  );

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  assign req_ready  = (state_q == IDLE) && !fill_valid && !flush_req;
  assign fill_ready = (state_q == IDLE);
  assign fill_way   = pick_victim(valid_q[fill_set], rr_q[fill_set]);
  assign flush_busy = (state_q == FLUSH);
  assign flush_done = (state_q == FLUSH) && (cnt_q == SET_W'(SETS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    tag_d       = tag_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_valid) begin
          tag_d[fill_set][fill_way]   = fill_tag;
          valid_d[fill_set][fill_way] = 1'b1;
          if (WAYS > 1 && (&valid_q[fill_set]))
            rr_d[fill_set] = rr_q[fill_set] + WAY_W'(1);
        end
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
        if (req_valid && req_ready) begin
          rsp_valid_d  = 1'b1;
          rsp_d.hit    = |hit_vec;
          rsp_d.miss   = ~(|hit_vec);
          rsp_d.multi  = ($countones(hit_vec) > 1);
          rsp_d.way    = hit_way;
          rsp_d.victim = pick_victim(valid_q[req_set], rr_q[req_set]);
          rsp_d.tag    = req_tag;
          rsp_d.set    = req_set;
          rsp_d.word   = req_word;
        end
      end
      FLUSH: begin
        valid_d[cnt_q] = '0;
        rr_d[cnt_q]    = '0;
        cnt_d          = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      rr_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Tag storage carries no reset; valid bits alone gate matches.
  always_ff @(posedge clk) tag_q <= tag_d;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_q.hit;
  assign rsp_miss   = rsp_q.miss;
  assign rsp_multi  = rsp_q.multi;
  assign rsp_way    = rsp_q.way;
  assign rsp_victim = rsp_q.victim;
  assign rsp_tag    = rsp_q.tag;
  assign rsp_set    = rsp_q.set;
  assign rsp_word   = rsp_q.word;
endmodule

// File: tb/tb_cache_tag_lookup_assoc.sv
// Directed bench for cache_tag_lookup_assoc at default parameters (4 sets, 2 ways, 28-bit tags).

module tb_cache_tag_lookup_assoc;
  localparam int TAG_W = 28;
  localparam int SET_W = 2;
  localparam int WORD_W = 2;
  localparam int WAY_W = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [TAG_W-1:0]  req_tag;
  logic [SET_W-1:0]  req_set;
  logic [WORD_W-1:0] req_word;
  logic              rsp_valid, rsp_hit, rsp_miss, rsp_multi;
  logic [WAY_W-1:0]  rsp_way, rsp_victim;
  logic [TAG_W-1:0]  rsp_tag;
  logic [SET_W-1:0]  rsp_set;
  logic [WORD_W-1:0] rsp_word;
  logic              fill_valid, fill_ready;
  logic [TAG_W-1:0]  fill_tag;
  logic [SET_W-1:0]  fill_set;
  logic [WAY_W-1:0]  fill_way;
  logic              flush_req, flush_busy, flush_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_tag_lookup_assoc dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_set(req_set), .req_word(req_word),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss),
    .rsp_way(rsp_way), .rsp_victim(rsp_victim), .rsp_multi(rsp_multi),
    .rsp_tag(rsp_tag), .rsp_set(rsp_set), .rsp_word(rsp_word),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag),
    .fill_set(fill_set), .fill_way(fill_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                      input logic [WAY_W-1:0] exp_way, input string name);
    fill_valid = 1'b1; fill_set = s; fill_tag = t;
    #1;
    chk({name, "_fill_way"}, fill_way, exp_way);
    chk({name, "_req_ready_lo"}, req_ready, 1'b0);
    tick();
    fill_valid = 1'b0;
  endtask

  task automatic lookup(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_set = s; req_tag = t; req_word = 2'd3;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_set = '0; req_word = '0;
    fill_valid = 1'b0; fill_tag = '0; fill_set = '0; flush_req = 1'b0;
    #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_miss", rsp_miss, 1'b0);
    chk("rst_flush_busy", flush_busy, 1'b0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_fill_ready", fill_ready, 1'b1);

    // Cold lookup misses
    lookup(2'd1, 28'h0000ABC);
    chk("cold_rsp_valid", rsp_valid, 1'b1);
    chk("cold_miss", rsp_miss, 1'b1);
    chk("cold_hit", rsp_hit, 1'b0);
    chk("cold_victim", rsp_victim, 1'b0);
    chk("cold_set", rsp_set, 2'd1);
    chk("cold_tag", rsp_tag, 28'h0000ABC);
    chk("cold_word", rsp_word, 2'd3);
    tick();
    chk("pulse_low", rsp_valid, 1'b0);
    chk("hold_miss", rsp_miss, 1'b1);

    // Fill then hit
    fill(2'd1, 28'h0000ABC, 1'b0, "f1");
    lookup(2'd1, 28'h0000ABC);
    chk("hit1_hit", rsp_hit, 1'b1);
    chk("hit1_miss", rsp_miss, 1'b0);
    chk("hit1_way", rsp_way, 1'b0);
    chk("hit1_victim", rsp_victim, 1'b1);
    chk("hit1_multi", rsp_multi, 1'b0);
    fill(2'd1, 28'h0000DEF, 1'b1, "f2");

    // Round-robin wrap in set 2
    fill(2'd2, 28'h00000A1, 1'b0, "rrA");
    fill(2'd2, 28'h00000B2, 1'b1, "rrB");
    fill(2'd2, 28'h00000C3, 1'b0, "rrC");
    req_valid = 1'b1; req_set = 2'd2; req_tag = 28'h00000A1;
    tick();
    chk("rrA_miss", rsp_miss, 1'b1);
    chk("rrA_victim", rsp_victim, 1'b1);
    req_tag = 28'h00000B2;
    tick();
    req_valid = 1'b0;
    chk("rrB_valid", rsp_valid, 1'b1);
    chk("rrB_hit", rsp_hit, 1'b1);
    chk("rrB_way", rsp_way, 1'b1);

    // Duplicate tag in set 3 flags multi-match
    fill(2'd3, 28'h0000077, 1'b0, "m0");
    fill(2'd3, 28'h0000077, 1'b1, "m1");
    lookup(2'd3, 28'h0000077);
    chk("multi_hit", rsp_hit, 1'b1);
    chk("multi_way", rsp_way, 1'b0);
    chk("multi_flag", rsp_multi, 1'b1);
    fill(2'd0, 28'h0000111, 1'b0, "s0");

    // Flush sweep over 4 sets
    flush_req = 1'b1;
    #1;
    chk("fl_req_ready", req_ready, 1'b0);
    chk("fl_fill_ready", fill_ready, 1'b1);
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fl_busy", flush_busy, 1'b1);
      chk("fl_done", flush_done, (i == 3));
      chk("fl_sweep_req_ready", req_ready, 1'b0);
      chk("fl_sweep_fill_ready", fill_ready, 1'b0);
      tick();
    end
    chk("fl_busy_end", flush_busy, 1'b0);
    chk("fl_done_end", flush_done, 1'b0);
    chk("fl_ready_end", req_ready, 1'b1);

    // Back-to-back lookups after flush, all miss
    req_valid = 1'b1;
    req_tag = 28'h0000ABC;
    for (int s = 0; s < 4; s++) begin
      req_set = SET_W'(s);
      tick();
      chk("b2b_valid", rsp_valid, 1'b1);
      chk("b2b_set", rsp_set, s);
      chk("b2b_miss", rsp_miss, 1'b1);
      chk("b2b_victim", rsp_victim, 1'b0);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_end", rsp_valid, 1'b0);

    // Reset asserted mid-flush at cnt=2
    fill(2'd3, 28'h0000333, 1'b0, "pre");
    lookup(2'd3, 28'h0000333);
    chk("pre_hit", rsp_hit, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    chk("mid_busy", flush_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", flush_busy, 1'b0);
    chk("mid_rst_hit", rsp_hit, 1'b0);
    chk("mid_rst_set", rsp_set, 2'd0);
    chk("mid_rst_tag", rsp_tag, 28'h0);
    chk("mid_rst_done", flush_done, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    lookup(2'd3, 28'h0000333);
    chk("post_rst_valid", rsp_valid, 1'b1);
    chk("post_rst_miss", rsp_miss, 1'b1);
    chk("post_rst_victim", rsp_victim, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
